// File: rtl/ring_monitor.sv
// ring_monitor
//   Integrity monitor for a rotating one-hot ring-counter bus. Each valid
//   sample is checked for being one-hot and for being exactly one
//   rotate-left step after the previous sample. The monitor locks after
//   LOCK_CNT consecutive good samples. While locked, one-hot and sequence
//   violations are counted in a saturating error counter.
//
// Ports
//   clk         single clock, rising edge
//   init_n      asynchronous active-low reset
//   ring_in     sampled ring-counter value (WIDTH bits)
//   ring_vld    ring_in is valid this cycle
//   clr_cnt     synchronous clear of err_count
//   index       bit position of the set bit in the last one-hot sample
//   index_vld   one-cycle strobe: index updated from a one-hot sample
//   locked      rotation sequence verified
//   onehot_err  one-cycle pulse: valid sample was not one-hot
//   seq_err     one-cycle pulse: one-hot sample in LOCKED broke the rotation
//   err_count   saturating count of errors detected while LOCKED
module ring_monitor #(
    parameter int  WIDTH     = 8,
    parameter int  LOCK_CNT  = 3,
    parameter int  ERR_CNT_W = 8,
    localparam int IDX_W     = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 init_n,
    input  logic [WIDTH-1:0]     ring_in,
    input  logic                 ring_vld,
    input  logic                 clr_cnt,
    output logic [IDX_W-1:0]     index,
    output logic                 index_vld,
    output logic                 locked,
    output logic                 onehot_err,
    output logic                 seq_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam logic [WIDTH-1:0] RING_ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } state_t;

    state_t              state;
    logic [GOOD_W-1:0]   good_cnt;
    logic [WIDTH-1:0]    reference;

    logic                sample_onehot;
    logic [IDX_W-1:0]    sample_idx;
    logic [WIDTH-1:0]    expected;
    logic                rotation_ok;
    logic                count_err;
    logic [ERR_CNT_W-1:0] err_next;

    // Sample classification
    always_comb begin
        // x & (x-1) clears the lowest set bit; zero result means at most one bit
        sample_onehot = (ring_in != '0) && ((ring_in & (ring_in - RING_ONE)) == '0);

        sample_idx = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (ring_in[i]) begin
                sample_idx = IDX_W'(i);
            end
        end

        // Rotate left, MSB wraps to bit 0
        expected    = {reference[WIDTH-2:0], reference[WIDTH-1]};
        rotation_ok = sample_onehot && (ring_in == expected);
    end

    // Error counter next value: any non-matching valid sample in LOCKED is an
    // error. A clear coinciding with an error leaves exactly that one error.
    always_comb begin
        count_err = ring_vld && (state == LOCKED) && !rotation_ok;
        err_next  = err_count;
        if (clr_cnt) begin
            err_next = count_err ? ERR_CNT_W'(1) : '0;
        end else if (count_err && (err_count != '1)) begin
            err_next = err_count + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state      <= HUNT;
            good_cnt   <= '0;
            reference  <= '0;
            index      <= '0;
            index_vld  <= 1'b0;
            locked     <= 1'b0;
            onehot_err <= 1'b0;
            seq_err    <= 1'b0;
            err_count  <= '0;
        end else begin
            index_vld  <= 1'b0;
            onehot_err <= 1'b0;
            seq_err    <= 1'b0;
            err_count  <= err_next;

            if (ring_vld) begin
                if (sample_onehot) begin
                    index     <= sample_idx;
                    index_vld <= 1'b1;
                end else begin
                    onehot_err <= 1'b1;
                end

                case (state)
                    HUNT: begin
                        if (sample_onehot) begin
                            state     <= VERIFY;
                            good_cnt  <= GOOD_W'(1);
                            reference <= ring_in;
                        end
                    end

                    VERIFY: begin
                        if (rotation_ok) begin
                            reference <= ring_in;
                            good_cnt  <= good_cnt + GOOD_W'(1);
                            if (good_cnt == GOOD_W'(LOCK_CNT - 1)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else if (sample_onehot) begin
                            // Restart the run from this sample; not an error yet
                            good_cnt  <= GOOD_W'(1);
                            reference <= ring_in;
                        end else begin
                            state    <= HUNT;
                            good_cnt <= '0;
                        end
                    end

                    LOCKED: begin
                        if (rotation_ok) begin
                            reference <= ring_in;
                        end else if (sample_onehot) begin
                            seq_err   <= 1'b1;
                            locked    <= 1'b0;
                            state     <= VERIFY;
                            good_cnt  <= GOOD_W'(1);
                            reference <= ring_in;
                        end else begin
                            locked   <= 1'b0;
                            state    <= HUNT;
                            good_cnt <= '0;
                        end
                    end

                    default: begin
                        state    <= HUNT;
                        good_cnt <= '0;
                        locked   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ring_monitor.sv
// tb_ring_monitor
//   Directed bench for ring_monitor. Two instances share the stimulus: one
//   with default parameters and one with a 2-bit error counter so that
//   saturation is reachable. A behavioural model (run length, index
//   arithmetic, saturating counts) predicts every output each cycle, and
//   literal expectations at key points pin the model itself.
module tb_ring_monitor;

    localparam int W    = 8;
    localparam int LOCK = 3;

    logic       clk = 1'b0;
    logic       init_n = 1'b0;
    logic [7:0] ring_in = '0;
    logic       ring_vld = 1'b0;
    logic       clr_cnt = 1'b0;

    logic [2:0] index_a, index_b;
    logic       index_vld_a, index_vld_b;
    logic       locked_a, locked_b;
    logic       onehot_err_a, onehot_err_b;
    logic       seq_err_a, seq_err_b;
    logic [7:0] err_count_a;
    logic [1:0] err_count_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ring_monitor u_dut (
        .clk        (clk),
        .init_n     (init_n),
        .ring_in    (ring_in),
        .ring_vld   (ring_vld),
        .clr_cnt    (clr_cnt),
        .index      (index_a),
        .index_vld  (index_vld_a),
        .locked     (locked_a),
        .onehot_err (onehot_err_a),
        .seq_err    (seq_err_a),
        .err_count  (err_count_a)
    );

    ring_monitor #(.ERR_CNT_W(2)) u_sat (
        .clk        (clk),
        .init_n     (init_n),
        .ring_in    (ring_in),
        .ring_vld   (ring_vld),
        .clr_cnt    (clr_cnt),
        .index      (index_b),
        .index_vld  (index_vld_b),
        .locked     (locked_b),
        .onehot_err (onehot_err_b),
        .seq_err    (seq_err_b),
        .err_count  (err_count_b)
    );

    // ---------------- behavioural model ----------------
    int m_index  = 0;
    int m_ivld   = 0;
    int m_locked = 0;
    int m_oerr   = 0;
    int m_serr   = 0;
    int m_e8     = 0;
    int m_e2     = 0;
    int m_run    = 0;   // consecutive good rotation samples so far
    int m_ref    = 0;   // index of the previous good sample

    always @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            m_index = 0; m_ivld = 0; m_locked = 0; m_oerr = 0; m_serr = 0;
            m_e8 = 0; m_e2 = 0; m_run = 0; m_ref = 0;
        end else begin
            int  idx;
            bit  oh, next_ok, err;
            m_ivld = 0; m_oerr = 0; m_serr = 0; err = 0; idx = 0;
            if (ring_vld) begin
                oh = ($countones(ring_in) == 1);
                if (oh) begin
                    for (int b = 0; b < W; b++) if (ring_in[b]) idx = b;
                    m_index = idx;
                    m_ivld  = 1;
                end else begin
                    m_oerr = 1;
                end
                next_ok = oh && (m_run > 0) && (idx == (m_ref + 1) % W);
                if (m_locked != 0) begin
                    if (next_ok) begin
                        m_ref = idx;
                    end else begin
                        err = 1;
                        m_locked = 0;
                        if (oh) begin
                            m_serr = 1; m_run = 1; m_ref = idx;
                        end else begin
                            m_run = 0;
                        end
                    end
                end else begin
                    if (!oh) begin
                        m_run = 0;
                    end else if (next_ok) begin
                        m_run++;
                        m_ref = idx;
                        if (m_run == LOCK) m_locked = 1;
                    end else begin
                        m_run = 1; m_ref = idx;
                    end
                end
            end
            if (clr_cnt) begin
                m_e8 = err ? 1 : 0;
                m_e2 = err ? 1 : 0;
            end else if (err) begin
                if (m_e8 < 255) m_e8++;
                if (m_e2 < 3)   m_e2++;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison, away from the rising edge
    always @(negedge clk) begin
        chk("index_a",      int'(index_a),      m_index);
        chk("index_vld_a",  int'(index_vld_a),  m_ivld);
        chk("locked_a",     int'(locked_a),     m_locked);
        chk("onehot_err_a", int'(onehot_err_a), m_oerr);
        chk("seq_err_a",    int'(seq_err_a),    m_serr);
        chk("err_count_a",  int'(err_count_a),  m_e8);
        chk("index_b",      int'(index_b),      m_index);
        chk("index_vld_b",  int'(index_vld_b),  m_ivld);
        chk("locked_b",     int'(locked_b),     m_locked);
        chk("onehot_err_b", int'(onehot_err_b), m_oerr);
        chk("seq_err_b",    int'(seq_err_b),    m_serr);
        chk("err_count_b",  int'(err_count_b),  m_e2);
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] r, input logic v, input logic c);
        @(negedge clk);
        ring_in  = r;
        ring_vld = v;
        clr_cnt  = c;
        @(posedge clk);
        #1;
        ring_vld = 1'b0;
        clr_cnt  = 1'b0;
    endtask

    logic [7:0] rv;
    int         sel;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_index",  int'(index_a),     0);
        chk("rst_locked", int'(locked_a),    0);
        chk("rst_err",    int'(err_count_a), 0);
        @(negedge clk);
        init_n = 1'b1;

        // Lock quickly, then reset asynchronously mid-lock
        send(8'h01, 1, 0);
        chk("first_index", int'(index_a), 0);
        chk("first_ivld",  int'(index_vld_a), 1);
        send(8'h02, 1, 0);
        send(8'h04, 1, 0);
        chk("pre_rst_locked", int'(locked_a), 1);
        #2;
        init_n = 1'b0;
        #1;
        chk("async_index",  int'(index_a),  0);
        chk("async_locked", int'(locked_a), 0);
        chk("async_ivld",   int'(index_vld_a), 0);
        chk("async_locked_b", int'(locked_b), 0);
        @(negedge clk);
        init_n = 1'b1;
        send(8'h01, 1, 0);
        chk("post_rst_index", int'(index_a), 0);
        chk("post_rst_ivld",  int'(index_vld_a), 1);

        // Lock and wrap
        send(8'h20, 1, 0);
        chk("wrap_idx5", int'(index_a), 5);
        send(8'h40, 1, 0);
        chk("wrap_idx6", int'(index_a), 6);
        chk("wrap_not_locked", int'(locked_a), 0);
        send(8'h80, 1, 0);
        chk("wrap_idx7", int'(index_a), 7);
        chk("wrap_locked", int'(locked_a), 1);
        send(8'h01, 1, 0);
        chk("wrap_idx0", int'(index_a), 0);
        chk("wrap_still_locked", int'(locked_a), 1);
        chk("wrap_no_serr", int'(seq_err_a), 0);

        // One-hot fault while locked
        send(8'h03, 1, 0);
        chk("oh_err",    int'(onehot_err_a), 1);
        chk("oh_count",  int'(err_count_a), 1);
        chk("oh_unlock", int'(locked_a), 0);
        chk("oh_hold",   int'(index_a), 0);
        send(8'h04, 1, 0);
        send(8'h08, 1, 0);
        send(8'h10, 1, 0);
        chk("oh_relock", int'(locked_a), 1);

        // Sequence fault while locked
        send(8'h40, 1, 0);
        chk("seq_err",    int'(seq_err_a), 1);
        chk("seq_index",  int'(index_a), 6);
        chk("seq_count",  int'(err_count_a), 2);
        chk("seq_unlock", int'(locked_a), 0);
        send(8'h80, 1, 0);
        send(8'h01, 1, 0);
        chk("seq_relock", int'(locked_a), 1);

        // Gaps mid-lock with garbage on the bus
        for (int g = 0; g < 5; g++) send(8'hFF, 0, 0);
        chk("gap_locked", int'(locked_a), 1);
        send(8'h02, 1, 0);
        chk("gap_resume_idx", int'(index_a), 1);
        chk("gap_resume_ok",  int'(seq_err_a), 0);
        chk("gap_count",      int'(err_count_a), 2);

        // Third locked error (sequence), relock
        send(8'h10, 1, 0);
        chk("e3_sat", int'(err_count_b), 3);
        send(8'h20, 1, 0);
        send(8'h40, 1, 0);
        // Fourth (one-hot), then a wrong one-hot in VERIFY is not a seq_err
        send(8'h00, 1, 0);
        send(8'h01, 1, 0);
        send(8'h08, 1, 0);
        chk("verify_no_serr", int'(seq_err_a), 0);
        send(8'h10, 1, 0);
        send(8'h20, 1, 0);
        chk("verify_relock", int'(locked_a), 1);
        // Fifth (sequence)
        send(8'h01, 1, 0);
        chk("e5_count8", int'(err_count_a), 5);
        chk("e5_sat2",   int'(err_count_b), 3);
        send(8'h02, 1, 0);
        send(8'h04, 1, 0);
        // Sixth error together with clear
        send(8'hFF, 1, 1);
        chk("clr_err_a", int'(err_count_a), 1);
        chk("clr_err_b", int'(err_count_b), 1);
        // Non-one-hot in HUNT: pulse, no count
        send(8'h00, 1, 0);
        chk("hunt_oerr",  int'(onehot_err_a), 1);
        chk("hunt_count", int'(err_count_b), 1);
        // Clear alone
        send(8'h00, 0, 1);
        chk("clr_alone", int'(err_count_a), 0);

        // Mostly-rotating traffic with occasional faults, gaps and clears
        rv = 8'h01;
        for (int k = 0; k < 200; k++) begin
            sel = int'($urandom_range(0, 15));
            if (sel < 10) begin
                rv = {rv[6:0], rv[7]};
                send(rv, 1, 0);
            end else if (sel == 10) begin
                send(8'($urandom), 1, 0);
            end else if (sel == 11) begin
                rv = 8'h01 << $urandom_range(0, 7);
                send(rv, 1, 0);
            end else if (sel == 12) begin
                rv = {rv[6:0], rv[7]};
                send(rv, 1, 1);
            end else begin
                send(8'($urandom), 0, sel == 15);
            end
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
